// File: rtl/led_pulse_encoder_if.sv
// Handshake and message bus between the passcode logic and the LED pulse encoder.
// The master drives the request and message words; the slave returns the LED drive and its status.
interface led_pulse_encoder_if #(
    parameter int NUM_WORDS = 4,
    parameter int WORD_W    = 5
);
    localparam int WI_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    logic                        start;
    logic [NUM_WORDS*WORD_W-1:0] words;
    logic                        repeat_en;
    logic                        led;
    logic                        busy;
    logic                        done;
    logic [WI_W-1:0]             word_idx;
    logic [BI_W-1:0]             bit_idx;

    modport master (
        output start, words, repeat_en,
        input  led, busy, done, word_idx, bit_idx
    );

    modport slave (
        input  start, words, repeat_en,
        output led, busy, done, word_idx, bit_idx
    );
endinterface

// File: rtl/led_pulse_encoder.sv
// Serialises a latched message onto one LED: a short pulse is a 0 and a long pulse is a 1.
// Every word is followed by a burst of fast separator blinks, and the message can optionally loop.
module led_pulse_encoder #(
    parameter int WORD_W     = 5,
    parameter int NUM_WORDS  = 4,
    parameter int TICK_DIV   = 1,
    parameter int SHORT_T    = 5,
    parameter int LONG_T     = 10,
    parameter int BIT_T      = 20,
    parameter int SEP_PULSES = 4
) (
    input  logic               clk,
    input  logic               rst,
    led_pulse_encoder_if.slave bus
);
    localparam int WI_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BI_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_MAX = (BIT_T > 2*SEP_PULSES) ? BIT_T : 2*SEP_PULSES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SHORT_END = CNT_W'(SHORT_T - 1);
    localparam logic [CNT_W-1:0] LONG_END  = CNT_W'(LONG_T - 1);
    localparam logic [CNT_W-1:0] SLOT_END  = CNT_W'(BIT_T - 1);
    localparam logic [CNT_W-1:0] SEP_END   = CNT_W'(2*SEP_PULSES - 1);
    localparam logic [PS_W-1:0]  PS_END    = PS_W'(TICK_DIV - 1);
    localparam logic [WI_W-1:0]  LAST_WORD = WI_W'(NUM_WORDS - 1);
    localparam logic [BI_W-1:0]  TOP_BIT   = BI_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        SPACE,
        SEP,
        FIN
    } state_t;

    state_t                      state_reg;
    logic [NUM_WORDS*WORD_W-1:0] words_reg;
    logic [PS_W-1:0]             presc_reg;
    logic [CNT_W-1:0]            tcnt_reg;
    logic                        led_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic [WI_W-1:0]             word_idx_reg;
    logic [BI_W-1:0]             bit_idx_reg;

    logic [WORD_W-1:0] word_arr [NUM_WORDS];
    logic              tick;
    logic              cur_bit;
    logic [CNT_W-1:0]  mark_end;

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
            assign word_arr[gi] = words_reg[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign tick     = (presc_reg == PS_END);
    assign cur_bit  = word_arr[word_idx_reg][bit_idx_reg];
    assign mark_end = cur_bit ? LONG_END : SHORT_END;

    // tcnt_reg runs across the whole bit slot, so MARK and SPACE share one counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            words_reg    <= '0;
            presc_reg    <= '0;
            tcnt_reg     <= '0;
            led_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            word_idx_reg <= '0;
            bit_idx_reg  <= '0;
        end else begin
            done_reg <= 1'b0;

            if (!busy_reg || tick)
                presc_reg <= '0;
            else
                presc_reg <= presc_reg + 1'b1;

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        words_reg    <= bus.words;
                        busy_reg     <= 1'b1;
                        led_reg      <= 1'b1;
                        word_idx_reg <= '0;
                        bit_idx_reg  <= TOP_BIT;
                        tcnt_reg     <= '0;
                        state_reg    <= MARK;
                    end
                end

                MARK: begin
                    if (tick) begin
                        tcnt_reg <= tcnt_reg + 1'b1;
                        if (tcnt_reg == mark_end) begin
                            led_reg   <= 1'b0;
                            state_reg <= SPACE;
                        end
                    end
                end

                SPACE: begin
                    if (tick) begin
                        if (tcnt_reg == SLOT_END) begin
                            tcnt_reg <= '0;
                            led_reg  <= 1'b1;
                            if (bit_idx_reg != '0) begin
                                bit_idx_reg <= bit_idx_reg - 1'b1;
                                state_reg   <= MARK;
                            end else begin
                                state_reg <= SEP;
                            end
                        end else begin
                            tcnt_reg <= tcnt_reg + 1'b1;
                        end
                    end
                end

                SEP: begin
                    if (tick) begin
                        if (tcnt_reg == SEP_END) begin
                            tcnt_reg <= '0;
                            if (word_idx_reg != LAST_WORD) begin
                                word_idx_reg <= word_idx_reg + 1'b1;
                                bit_idx_reg  <= TOP_BIT;
                                led_reg      <= 1'b1;
                                state_reg    <= MARK;
                            end else begin
                                led_reg   <= 1'b0;
                                state_reg <= FIN;
                            end
                        end else begin
                            // Next tick index is odd exactly when the current one is even.
                            tcnt_reg <= tcnt_reg + 1'b1;
                            led_reg  <= tcnt_reg[0];
                        end
                    end
                end

                FIN: begin
                    tcnt_reg <= '0;
                    if (bus.repeat_en) begin
                        word_idx_reg <= '0;
                        bit_idx_reg  <= TOP_BIT;
                        led_reg      <= 1'b1;
                        state_reg    <= MARK;
                    end else begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        led_reg   <= 1'b0;
                        state_reg <= IDLE;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.led      = led_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.word_idx = word_idx_reg;
    assign bus.bit_idx  = bit_idx_reg;
endmodule

// File: tb/tb_led_pulse_encoder.sv
// Directed bench for led_pulse_encoder: a table of hand-computed waveform points plus
// sequences for prescaling, repeat mode, asynchronous abort and start handling.
module tb_led_pulse_encoder;
    localparam logic [19:0] P1 = 20'h00016;  // word0 = 10110, others 0
    localparam logic [19:0] P2 = 20'hFFFFF;  // all ones
    localparam logic [19:0] P3 = 20'h08200;  // word1 = 10000, word3 = 00001

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    led_pulse_encoder_if #(.NUM_WORDS(4), .WORD_W(5)) bus_a ();
    led_pulse_encoder_if #(.NUM_WORDS(4), .WORD_W(5)) bus_b ();

    led_pulse_encoder #(.WORD_W(5), .NUM_WORDS(4), .TICK_DIV(1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    led_pulse_encoder #(.WORD_W(5), .NUM_WORDS(4), .TICK_DIV(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    typedef struct {
        logic [19:0] words;
        int          cyc;
        logic        led;
        logic        busy;
        logic        done;
        logic        chk_idx;
        logic [1:0]  widx;
        logic [2:0]  bidx;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;

    function automatic vec_t mk(logic [19:0] w, int c, logic l, logic b, logic d,
                                logic ci, logic [1:0] wi, logic [2:0] bi);
        vec_t v;
        v.words = w; v.cyc = c; v.led = l; v.busy = b; v.done = d;
        v.chk_idx = ci; v.widx = wi; v.bidx = bi;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.repeat_en = 1'b0; bus_a.words = '0;
        bus_b.start = 1'b0; bus_b.repeat_en = 1'b0; bus_b.words = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cyc = 0;
    endtask

    // Accept happens on the next posedge; cyc=1 is the first sample after it.
    task automatic accept_a(input logic [19:0] w, input logic rep);
        bus_a.words = w; bus_a.repeat_en = rep; bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        cyc = 1;
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic measure_b(input string tag);
        int hi;
        int c;
        bus_b.words = P1; bus_b.repeat_en = 1'b0; bus_b.start = 1'b1;
        @(negedge clk);
        bus_b.start = 1'b0;
        c = 1; hi = 0;
        while (bus_b.led === 1'b1 && c < 200) begin
            hi++;
            @(negedge clk);
            c++;
        end
        cyc = c;
        check({tag, "_long_len"}, hi, 40);
        while (bus_b.led !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        cyc = c;
        check({tag, "_slot_rise"}, c, 81);
        $display("tdiv4 %s: high=%0d next_rise=%0d", tag, hi, c);
    endtask

    initial begin
        int dcnt;
        int dcyc;

        // P1: 10110 in word 0, zeros elsewhere
        vecs.push_back(mk(P1,   1, 1, 1, 0, 1, 0, 4));
        vecs.push_back(mk(P1,  10, 1, 1, 0, 1, 0, 4));
        vecs.push_back(mk(P1,  11, 0, 1, 0, 1, 0, 4));
        vecs.push_back(mk(P1,  20, 0, 1, 0, 1, 0, 4));
        vecs.push_back(mk(P1,  21, 1, 1, 0, 1, 0, 3));
        vecs.push_back(mk(P1,  25, 1, 1, 0, 1, 0, 3));
        vecs.push_back(mk(P1,  26, 0, 1, 0, 1, 0, 3));
        vecs.push_back(mk(P1,  81, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(P1,  86, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(P1, 101, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(P1, 102, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(P1, 107, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(P1, 108, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(P1, 109, 1, 1, 0, 1, 1, 4));
        vecs.push_back(mk(P1, 114, 0, 1, 0, 1, 1, 4));
        vecs.push_back(mk(P1, 432, 0, 1, 0, 1, 3, 0));
        vecs.push_back(mk(P1, 433, 0, 1, 0, 1, 3, 0));
        vecs.push_back(mk(P1, 434, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(P1, 435, 0, 0, 0, 0, 0, 0));
        // P2: all ones
        vecs.push_back(mk(P2,  10, 1, 1, 0, 1, 0, 4));
        vecs.push_back(mk(P2,  11, 0, 1, 0, 1, 0, 4));
        vecs.push_back(mk(P2,  90, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(P2,  91, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(P2, 118, 1, 1, 0, 1, 1, 4));
        vecs.push_back(mk(P2, 217, 1, 1, 0, 1, 2, 4));
        vecs.push_back(mk(P2, 325, 1, 1, 0, 1, 3, 4));
        vecs.push_back(mk(P2, 414, 1, 1, 0, 1, 3, 0));
        vecs.push_back(mk(P2, 415, 0, 1, 0, 1, 3, 0));
        // P3: word order and MSB-first
        vecs.push_back(mk(P3,  10, 0, 1, 0, 1, 0, 4));
        vecs.push_back(mk(P3, 118, 1, 1, 0, 1, 1, 4));
        vecs.push_back(mk(P3, 222, 0, 1, 0, 1, 2, 4));
        vecs.push_back(mk(P3, 330, 0, 1, 0, 1, 3, 4));
        vecs.push_back(mk(P3, 414, 1, 1, 0, 1, 3, 0));

        // Reset state
        do_reset();
        check("rst_led",  bus_a.led, 0);
        check("rst_busy", bus_a.busy, 0);
        check("rst_done", bus_a.done, 0);
        check("rst_widx", bus_a.word_idx, 0);
        check("rst_bidx", bus_a.bit_idx, 0);
        check("rst_led_b", bus_b.led, 0);
        $display("reset: led=%0b busy=%0b done=%0b", bus_a.led, bus_a.busy, bus_a.done);

        foreach (vecs[i]) begin
            do_reset();
            accept_a(vecs[i].words, 1'b0);
            go_to(vecs[i].cyc);
            check("vec_led",  bus_a.led,  vecs[i].led);
            check("vec_busy", bus_a.busy, vecs[i].busy);
            check("vec_done", bus_a.done, vecs[i].done);
            if (vecs[i].chk_idx) begin
                check("vec_widx", bus_a.word_idx, vecs[i].widx);
                check("vec_bidx", bus_a.bit_idx,  vecs[i].bidx);
            end
            $display("vec %0d words=%05h cyc=%0d led=%0b busy=%0b done=%0b widx=%0d bidx=%0d",
                     i, vecs[i].words, cyc, bus_a.led, bus_a.busy, bus_a.done,
                     bus_a.word_idx, bus_a.bit_idx);
        end

        // TICK_DIV=4: long pulse 40 clk, slot 80 clk; repeated after an idle gap
        do_reset();
        measure_b("first");
        do_reset();
        repeat (3) @(negedge clk);
        measure_b("second");

        // Repeat mode: no done on loop, latched words, stop at end of current pass
        do_reset();
        accept_a(P1, 1'b1);
        dcnt = 0; dcyc = 0;
        for (int c = 2; c <= 900; c++) begin
            @(negedge clk);
            cyc = c;
            if (bus_a.done === 1'b1) begin
                dcnt++;
                dcyc = c;
            end
            if (c == 200) bus_a.words = P2;
            if (c == 500) bus_a.repeat_en = 1'b0;
            if (c == 433) check("rep_fin_busy", bus_a.busy, 1);
            if (c == 434) begin
                check("rep_loop_led",  bus_a.led, 1);
                check("rep_loop_widx", bus_a.word_idx, 0);
                check("rep_loop_bidx", bus_a.bit_idx, 4);
                check("rep_loop_busy", bus_a.busy, 1);
            end
            if (c == 459) check("rep_latched_led", bus_a.led, 0);
            if (c == 867) check("rep_end_busy", bus_a.busy, 0);
        end
        check("rep_done_count", dcnt, 1);
        check("rep_done_cycle", dcyc, 867);
        $display("repeat: done_count=%0d done_cycle=%0d", dcnt, dcyc);

        // Asynchronous abort mid-MARK of word 2
        do_reset();
        accept_a(P2, 1'b0);
        go_to(220);
        check("abort_pre_led",  bus_a.led, 1);
        check("abort_pre_widx", bus_a.word_idx, 2);
        rst = 1'b1;
        #1;
        check("abort_led",  bus_a.led, 0);
        check("abort_busy", bus_a.busy, 0);
        check("abort_done", bus_a.done, 0);
        check("abort_widx", bus_a.word_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("abort_no_done", bus_a.done, 0);
        accept_a(P1, 1'b0);
        check("restart_widx", bus_a.word_idx, 0);
        go_to(10);
        check("restart_led10", bus_a.led, 1);
        go_to(11);
        check("restart_led11", bus_a.led, 0);
        $display("abort: restart led@11=%0b widx=%0d", bus_a.led, bus_a.word_idx);

        // start pulses while busy are ignored
        do_reset();
        accept_a(P1, 1'b0);
        go_to(50);
        bus_a.words = P2; bus_a.start = 1'b1;
        go_to(51);
        bus_a.start = 1'b0;
        go_to(109);
        check("busy_start_widx", bus_a.word_idx, 1);
        go_to(114);
        check("busy_start_led", bus_a.led, 0);
        go_to(150);
        bus_a.start = 1'b1;
        go_to(151);
        bus_a.start = 1'b0;
        go_to(433);
        check("busy_start_fin", bus_a.busy, 1);
        go_to(434);
        check("busy_start_done", bus_a.done, 1);
        go_to(436);
        check("busy_start_idle", bus_a.busy, 0);
        $display("start-while-busy: busy@436=%0b", bus_a.busy);

        // start held high: back-to-back messages
        do_reset();
        bus_a.words = P1; bus_a.repeat_en = 1'b0; bus_a.start = 1'b1;
        @(negedge clk);
        cyc = 1;
        go_to(434);
        check("held_gap_busy", bus_a.busy, 0);
        check("held_gap_done", bus_a.done, 1);
        go_to(435);
        check("held_next_busy", bus_a.busy, 1);
        check("held_next_led",  bus_a.led, 1);
        check("held_next_done", bus_a.done, 0);
        check("held_next_bidx", bus_a.bit_idx, 4);
        bus_a.start = 1'b0;
        go_to(444);
        check("held_next_led444", bus_a.led, 1);
        go_to(445);
        check("held_next_led445", bus_a.led, 0);
        $display("start-held: second message led@445=%0b", bus_a.led);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/led_pulse_encoder.md
Name: led_pulse_encoder

Overview:
- Serialises NUM_WORDS code words of WORD_W bits onto one LED as short/long pulses: a short pulse encodes 0, a long pulse encodes 1.
- Each word is followed by a fast separator blink.
- Generalises the fixed 4×5-bit LED blinker. Adds parameterised width, depth and timing, a tick prescaler, a start/busy/done handshake, repeat mode and an asynchronous reset.
- Sits between the passcode logic and the board LED pin.

Parameters:
- WORD_W, 5, bits per word; sent MSB first.
- NUM_WORDS, 4, words per message; word 0 is sent first.
- TICK_DIV, 1, clk cycles per timing tick (≥1).
- SHORT_T, 5, ticks LED is high for a 0 bit.
- LONG_T, 10, ticks LED is high for a 1 bit.
- BIT_T, 20, total ticks per bit slot. Must satisfy 1 ≤ SHORT_T < LONG_T < BIT_T.
- SEP_PULSES, 4, separator pulses after each word; each pulse is 1 tick high then 1 tick low.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request transmission; accepted only in IDLE.
- words  in  NUM_WORDS*WORD_W  message; word n = words[n*WORD_W +: WORD_W]. Latched on accept.
- repeat_en  in  1  loop the message continuously instead of finishing.
- led  out  1  encoded LED drive, registered.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse when the message completes (repeat_en=0).
- word_idx  out  clog2(NUM_WORDS) (min 1)  index of the word being sent.
- bit_idx  out  clog2(WORD_W) (min 1)  bit position being sent (WORD_W-1 down to 0).

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; led=0, busy=0, done=0, word_idx=0, bit_idx=0.
  - Prescaler, tick counter and latched words cleared.
  - Reset mid-message aborts with no done pulse.
- Prescaler:
  - Counts 0..TICK_DIV-1 while busy and asserts tick on the wrap.
  - Cleared on accept. TICK_DIV=1 ⇒ tick every cycle.
  - All durations below are in ticks.
- FSM states: IDLE, MARK, SPACE, SEP, FIN.
- IDLE:
  - start=1 at a clk edge ⇒ latch words; busy=1, led=1, word_idx=0, bit_idx=WORD_W-1; go to MARK with tick counter=0.
  - led rises on the same edge that samples start (1-cycle latency from start to led).
- MARK:
  - led=1.
  - After SHORT_T ticks (bit=0) or LONG_T ticks (bit=1) ⇒ led=0, go to SPACE.
- SPACE:
  - led=0 until the slot reaches BIT_T ticks in total.
  - If bit_idx>0 ⇒ bit_idx−1, led=1, go to MARK.
  - Else ⇒ go to SEP with led=1.
- SEP:
  - 2*SEP_PULSES ticks; led=1 on even ticks, 0 on odd ticks.
  - At the end, if word_idx<NUM_WORDS-1 ⇒ word_idx+1, bit_idx=WORD_W-1, led=1, go to MARK.
  - On the last word ⇒ go to FIN.
- FIN (single cycle):
  - repeat_en=1 ⇒ word_idx=0, bit_idx=WORD_W-1, led=1, go to MARK using the latched words (not re-sampled). done stays 0, busy stays 1.
  - repeat_en=0 ⇒ done=1 for this cycle, led=0, busy=0 on the next edge, return to IDLE.
- Message length (TICK_DIV=1):
  - NUM_WORDS*(WORD_W*BIT_T + 2*SEP_PULSES) cycles, plus 1 FIN cycle.
- Boundary rules:
  - start while busy is ignored; changes to words while busy are ignored.
  - start held high through FIN ⇒ new message accepted on the first IDLE edge.
  - Clearing repeat_en mid-loop takes effect at the next FIN only.
  - Counters are sized to hold BIT_T and 2*SEP_PULSES without wrap.

Test Plan:
- Defaults, TICK_DIV=1, words={5'h00,5'h00,5'h00,5'b10110}, start pulse at edge 0 ⇒ led high cycles 1–10 (long), low 11–20, high 21–25 (short). Word 0 separator is led=1,0,1,0,1,0,1,0 on cycles 101–108. done pulses exactly once, 433 cycles after accept; busy then falls.
- All-ones words ⇒ 20 high pulses of 10 cycles each, period 20, separators between words. word_idx steps 0→3; bit_idx steps 4→0 within each word.
- TICK_DIV=4, single-bit check ⇒ long pulse lasts 40 clk and the bit slot 80 clk. Prescaler restarts at accept.
- repeat_en=1 ⇒ after FIN, word 0 is resent with no done pulse. Changing words mid-loop has no effect. Dropping repeat_en ⇒ one done at the end of the current pass.
- Assert rst mid-MARK of word 2 ⇒ led, busy and done go 0 immediately (asynchronous), no done pulse. A new start then sends from word 0.
- start pulses during busy ⇒ ignored, message timing unchanged. start held high ⇒ back-to-back messages with the 1 FIN cycle between them.
